cordic_iter_ctrl: RTL and testbench
===================================

# cordic_iter_ctrl

Iteration sequencer for the CORDIC coprocessor: the control-side counterpart to the datapath's up/down counters and register enables. On a start request it captures an iteration limit, drives the operand load, steps an internal iteration index that addresses the arctangent LUT and selects the shift amount, fires the final scaling/output enable, and holds a result-valid flag until the consumer acknowledges it. It sits between the coprocessor's top-level handshake and the CORDIC datapath registers.

## Interface
- W, 5, width of iteration index and limit
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a new computation; sampled only in IDLE
- ack  in  1  consumer accepted the result; sampled only in DONE
- iter_max  in  W  index of the last iteration (iteration count = iter_max+1); captured on accepted start
- ready  out  1  controller idle, start will be accepted
- load_init  out  1  one-cycle pulse: datapath loads initial X/Y/Z operands
- enab_iter  out  1  datapath iteration registers update this cycle
- iter_idx  out  W  current iteration index (LUT address / shift amount)
- last_iter  out  1  enab_iter active and iter_idx == captured limit
- enab_final  out  1  one-cycle pulse: scaling/output register update
- done  out  1  result valid; held until ack

## Operation
- Moore FSM, states IDLE, LOAD, ITER, FINAL, DONE; state, iter_idx and captured limit are the only registers; all outputs decoded from them.
- IDLE: ready=1. start=1 -> capture iter_max into lim_reg, go LOAD. start=0 -> stay.
- LOAD: load_init=1; iter_idx forced to 0 at next edge; -> ITER.
- ITER: enab_iter=1. If iter_idx == lim_reg: last_iter=1, -> FINAL, iter_idx holds. Else iter_idx+1, stay.
- FINAL: enab_final=1; -> DONE.
- DONE: done=1. ack=1 -> IDLE; ack=0 -> stay.
- iter_idx counts up only, unsigned W-bit; never wraps since it stops at lim_reg <= 2^W-1.
- iter_max changes after capture have no effect until the next accepted start.
- start outside IDLE ignored (not queued); ack outside DONE ignored.
- iter_max = 0: exactly one ITER cycle with iter_idx=0, last_iter=1.
- iter_max = 2^W-1: 2^W ITER cycles, final idx all-ones, no wrap.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, iter_idx=0, lim_reg=0; outputs ready=1, load_init=0, enab_iter=0, last_iter=0, enab_final=0, done=0. Reset mid-operation aborts immediately; no done issued.
- start sampled high at edge 0 -> LOAD during cycle 1, ITER cycles 2 .. iter_max+2, FINAL cycle iter_max+3, done=1 from cycle iter_max+4.
- Start-to-done latency: iter_max+4 cycles. Minimum turnaround: ack at first DONE cycle -> IDLE next cycle; back-to-back start accepted there, giving iter_max+5 cycles per computation.
- ready deasserts the cycle after start is accepted; done and ready never high together.
- iter_idx valid for LUT addressing in the same cycle enab_iter is high.

## Configuration
- CORDIC_ABORT_EN defined: extra input abort (1 bit). abort=1 in LOAD, ITER or FINAL -> IDLE at next edge, iter_idx cleared, no enab_final, no done. abort in IDLE or DONE ignored. abort has priority over all other transitions.
- Undefined: no abort port; computation runs to DONE once started.

## Test plan
- Reset: hold reset=0 with start=1 -> ready=1, all other outputs 0, iter_idx=0; release, start accepted next edge.
- Nominal: iter_max=15, start one cycle -> load_init one cycle, enab_iter 16 cycles with iter_idx 0..15, last_iter only at 15, enab_final one cycle, done at cycle 19; hold ack=0 five cycles -> done stays 1; ack -> ready next cycle.
- Boundaries: iter_max=0 -> single ITER cycle idx 0 with last_iter=1, done at cycle 4; iter_max=31 -> idx 0..31, no wrap, done at cycle 35.
- Ignored inputs: pulse start during ITER and change iter_max mid-run to 3 -> sequence unchanged (still 16 iterations for captured 15); ack during ITER has no effect.
- Back-to-back: ack in first DONE cycle with start held high -> second run LOAD two cycles later, uses newly captured iter_max.
- Abort (CORDIC_ABORT_EN): abort at iter_idx=7 of a 16-iteration run -> IDLE next edge, ready=1, done never asserts, iter_idx=0; reset=0 at idx 7 in build without macro -> same idle state immediately.

Source files
------------

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: captures the iteration limit, steps the LUT/shift index and handshakes the result.
// Optional abort input enabled by defining CORDIC_ABORT_EN.
module cordic_iter_ctrl #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         ack,
  input  logic [W-1:0] iter_max,
`ifdef CORDIC_ABORT_EN
  input  logic         abort,
`endif
  output logic         ready,
  output logic         load_init,
  output logic         enab_iter,
  output logic [W-1:0] iter_idx,
  output logic         last_iter,
  output logic         enab_final,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FINAL,
    DONE
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] idx_q, idx_nxt;
  logic [W-1:0] lim_q, lim_nxt;
  logic         abort_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx_q <= '0;
      lim_q <= '0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      lim_q <= lim_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx_q;
    lim_nxt    = lim_q;
    ready      = 1'b0;
    load_init  = 1'b0;
    enab_iter  = 1'b0;
    last_iter  = 1'b0;
    enab_final = 1'b0;
    done       = 1'b0;
    abort_req  = 1'b0;
`ifdef CORDIC_ABORT_EN
    abort_req  = abort;
`endif

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          lim_nxt   = iter_max;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_init = 1'b1;
        idx_nxt   = '0;
        state_nxt = ITER;
      end
      ITER: begin
        enab_iter = 1'b1;
        // Index stops on the captured limit, so it can never wrap.
        if (idx_q == lim_q) begin
          last_iter = 1'b1;
          state_nxt = FINAL;
        end else begin
          idx_nxt = idx_q + 1'b1;
        end
      end
      FINAL: begin
        enab_final = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every transition while a computation is in flight.
    if (abort_req && (state == LOAD || state == ITER || state == FINAL)) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end
  end

  assign iter_idx = idx_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: table-driven runs, random runs against a cycle-count model, reset/abort sequences.
module tb_cordic_iter_ctrl;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] iter_max = '0;
`ifdef CORDIC_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         ready, load_init, enab_iter, last_iter, enab_final, done;
  logic [W-1:0] iter_idx;

  int n_checks = 0;
  int n_pass = 0;
  int prev_idx = 0;

  localparam logic [10:0] IDLE_ZERO = 11'b100_00000_000;

  cordic_iter_ctrl #(.W(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ack(ack),
    .iter_max(iter_max),
`ifdef CORDIC_ABORT_EN
    .abort(abort),
`endif
    .ready(ready),
    .load_init(load_init),
    .enab_iter(enab_iter),
    .iter_idx(iter_idx),
    .last_iter(last_iter),
    .enab_final(enab_final),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int lim;
    int ack_wait;
    bit mid;
    bit b2b;
    int exp_done;
  } vec_t;

  // {ready, load_init, enab_iter, iter_idx, last_iter, enab_final, done}
  function automatic logic [10:0] obs();
    return {ready, load_init, enab_iter, iter_idx, last_iter, enab_final, done};
  endfunction

  // Expected outputs c cycles after the accepted start edge, from the phase lengths alone.
  function automatic logic [10:0] ref_out(int c, int lim, int aw, int pidx);
    logic r = 0, l = 0, e = 0, la = 0, f = 0, d = 0;
    logic [W-1:0] ix;
    ix = W'(lim);
    if (c == 1) begin
      l = 1; ix = W'(pidx);
    end else if (c <= lim + 2) begin
      e = 1; ix = W'(c - 2); la = ((c - 2) == lim);
    end else if (c == lim + 3) begin
      f = 1;
    end else if (c <= lim + 4 + aw) begin
      d = 1;
    end else begin
      r = 1;
    end
    return {r, l, e, ix, la, f, d};
  endfunction

  task automatic check(string name, int c, logic [10:0] act, logic [10:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b required %b", name, c, act, exp);
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(int lim, int aw, bit mid, bit b2b, int nxt, int exp_done, string tag);
    int first_done = -1;
    int total = lim + 5 + aw;
    iter_max = W'(lim);
    start = 1'b1;
    ack = 1'b0;
    for (int c = 1; c <= total; c++) begin
      step();
      check(tag, c, obs(), ref_out(c, lim, aw, prev_idx));
      if (done === 1'b1 && first_done < 0) first_done = c;
      start = 1'b0;
      ack = 1'b0;
      if (mid && c == 5) begin
        start = 1'b1; ack = 1'b1; iter_max = 3;
      end
      if (c == lim + 4 + aw) begin
        ack = 1'b1;
        if (b2b) begin
          start = 1'b1; iter_max = W'(nxt);
        end
      end
    end
    check_int({tag, "_done_cycle"}, first_done, exp_done);
    prev_idx = lim;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{lim: 15, ack_wait: 5, mid: 0, b2b: 0, exp_done: 19};
    vecs[1] = '{lim: 0,  ack_wait: 0, mid: 0, b2b: 0, exp_done: 4};
    vecs[2] = '{lim: 31, ack_wait: 0, mid: 0, b2b: 0, exp_done: 35};
    vecs[3] = '{lim: 15, ack_wait: 0, mid: 1, b2b: 0, exp_done: 19};
    vecs[4] = '{lim: 15, ack_wait: 0, mid: 0, b2b: 1, exp_done: 19};
    vecs[5] = '{lim: 6,  ack_wait: 1, mid: 1, b2b: 0, exp_done: 10};

    // Reset held with start asserted.
    reset = 1'b0; start = 1'b1; iter_max = 15;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 0, obs(), IDLE_ZERO);
    reset = 1'b1;
    prev_idx = 0;

    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i].lim, vecs[i].ack_wait, vecs[i].mid, vecs[i].b2b,
              (i < 5) ? vecs[i+1].lim : 0, vecs[i].exp_done, $sformatf("vec%0d", i));
    end

    begin
      int rl, nl, aw;
      bit md, bb;
      rl = $urandom_range(0, 31);
      for (int r = 0; r < 20; r++) begin
        nl = $urandom_range(0, 31);
        aw = $urandom_range(0, 3);
        md = $urandom_range(0, 1) == 1 && rl >= 2;
        bb = $urandom_range(0, 1) == 1;
        run_one(rl, aw, md, bb, nl, rl + 4, $sformatf("rand%0d", r));
        rl = nl;
      end
    end

    // Asynchronous reset at iter_idx 7 of a 16-iteration run.
    step();
    start = 1'b0;
    iter_max = 15; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      check("rst_run", c, obs(), ref_out(c, 15, 0, prev_idx));
      start = 1'b0;
    end
    #2 reset = 1'b0;
    #1 check("rst_async", 0, obs(), IDLE_ZERO);
    step();
    reset = 1'b1;
    prev_idx = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("rst_after", c, obs(), IDLE_ZERO);
    end

`ifdef CORDIC_ABORT_EN
    iter_max = 15; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      check("abort_run", c, obs(), ref_out(c, 15, 0, prev_idx));
      start = 1'b0;
    end
    abort = 1'b1;
    step();
    check("abort_idle", 0, obs(), IDLE_ZERO);
    abort = 1'b0;
    prev_idx = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("abort_after", c, obs(), IDLE_ZERO);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
